// File: rtl/seg_pattern_checker.sv
// Receive-side checker for the "L o L e-tick H" seven-segment banner stream.
// Optional build macro: SEG_PATTERN_BLANK_SKIP_EN (blank FF patterns skip the sequence FSM).
module seg_pattern_checker #(
    parameter int LOCK_FRAMES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [7:0]       seg_in,
    input  logic             seg_valid,
    output logic [3:0]       sym,
    output logic             sym_valid,
    output logic             frame_done,
    output logic             err,
    output logic             locked,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [2:0]       dbg_state
);

    // Handshake: valid-only, no back-pressure. seg_in is consumed on every rising
    // Clk edge with seg_valid=1; results appear one cycle later with sym_valid=1.

    typedef enum logic [2:0] {
        IDX0 = 3'd0,
        IDX1 = 3'd1,
        IDX2 = 3'd2,
        IDX3 = 3'd3,
        IDX4 = 3'd4
    } state_t;

    localparam logic [7:0] PAT_L     = 8'hC7;
    localparam logic [7:0] PAT_O     = 8'hA3;
    localparam logic [7:0] PAT_E     = 8'hEF;
    localparam logic [7:0] PAT_H     = 8'h89;
    localparam logic [7:0] PAT_BLANK = 8'hFF;
    localparam logic [3:0] LOCK_GOOD = 4'(LOCK_FRAMES);

    function automatic logic [3:0] decode(input logic [7:0] p);
        case (p)
            PAT_L:     decode = 4'h1;
            PAT_O:     decode = 4'h2;
            PAT_E:     decode = 4'h3;
            PAT_H:     decode = 4'h4;
            PAT_BLANK: decode = 4'h0;
            default:   decode = 4'hF;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [3:0]       good_q, good_d;
    logic [3:0]       good_inc;
    logic [3:0]       sym_q, sym_d;
    logic             sym_valid_q, sym_valid_d;
    logic             frame_done_q, frame_done_d;
    logic             err_q, err_d;
    logic             locked_q, locked_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [7:0]       exp_pat;
    logic             blank;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= IDX0;
            good_q       <= 4'd0;
            sym_q        <= 4'd0;
            sym_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
            locked_q     <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            good_q       <= good_d;
            sym_q        <= sym_d;
            sym_valid_q  <= sym_valid_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
            locked_q     <= locked_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        good_d       = good_q;
        sym_d        = sym_q;
        sym_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        err_d        = 1'b0;
        locked_d     = locked_q;
        frame_cnt_d  = frame_cnt_q;
        blank        = 1'b0;
        good_inc     = (good_q >= LOCK_GOOD) ? LOCK_GOOD : good_q + 4'd1;

        case (state_q)
            IDX1:    exp_pat = PAT_O;
            IDX3:    exp_pat = PAT_E;
            IDX4:    exp_pat = PAT_H;
            default: exp_pat = PAT_L;
        endcase

        if (seg_valid) begin
            sym_d       = decode(seg_in);
            sym_valid_d = 1'b1;
`ifdef SEG_PATTERN_BLANK_SKIP_EN
            blank       = (seg_in == PAT_BLANK);
`else
            blank       = 1'b0;
`endif
            if (!blank) begin
                if (seg_in == exp_pat) begin
                    if (state_q == IDX4) begin
                        state_d      = IDX0;
                        frame_done_d = 1'b1;
                        good_d       = good_inc;
                        locked_d     = (good_inc == LOCK_GOOD);
                        if (frame_cnt_q != '1) frame_cnt_d = frame_cnt_q + CNT_W'(1);
                    end else begin
                        state_d = state_t'(state_q + 3'd1);
                    end
                end else begin
                    // Prefix-overlap recovery: keep whatever tail of the input is still a valid banner prefix.
                    if (seg_in == PAT_L)                         state_d = IDX1;
                    else if (seg_in == PAT_O && state_q == IDX3) state_d = IDX2;
                    else                                         state_d = IDX0;
                    // Junk while hunting only matters once the stream has been trusted.
                    if (state_q != IDX0 || locked_q) begin
                        good_d   = 4'd0;
                        locked_d = 1'b0;
                        err_d    = locked_q;
                    end
                end
            end
        end
    end

    assign sym        = sym_q;
    assign sym_valid  = sym_valid_q;
    assign frame_done = frame_done_q;
    assign err        = err_q;
    assign locked     = locked_q;
    assign frame_cnt  = frame_cnt_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_seg_pattern_checker.sv
// Directed testbench for seg_pattern_checker: hand-computed vectors, immediate assertions.
module tb_seg_pattern_checker;

  logic       Clk;
  logic       Reset_n;
  logic [7:0] seg_in;
  logic       seg_valid;

  logic [3:0] sym, sym_s;
  logic       sym_valid, sym_valid_s;
  logic       frame_done, frame_done_s;
  logic       err, err_s;
  logic       locked, locked_s;
  logic [7:0] frame_cnt;
  logic [1:0] frame_cnt_s;
  logic [2:0] dbg_state, dbg_state_s;

  int checks   = 0;
  int failures = 0;
  int step_no  = 0;

  // Clock/reset block
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  seg_pattern_checker #(.LOCK_FRAMES(2), .CNT_W(8)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .seg_in(seg_in), .seg_valid(seg_valid),
    .sym(sym), .sym_valid(sym_valid), .frame_done(frame_done), .err(err),
    .locked(locked), .frame_cnt(frame_cnt), .dbg_state(dbg_state)
  );

  seg_pattern_checker #(.LOCK_FRAMES(2), .CNT_W(2)) dut_small (
    .Clk(Clk), .Reset_n(Reset_n), .seg_in(seg_in), .seg_valid(seg_valid),
    .sym(sym_s), .sym_valid(sym_valid_s), .frame_done(frame_done_s), .err(err_s),
    .locked(locked_s), .frame_cnt(frame_cnt_s), .dbg_state(dbg_state_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL step%0d %s observed=%0h expected=%0h", step_no, tag, obs, exp);
    end
  endtask

  // Driver: present one input on the falling edge, return just after the sampling edge.
  task automatic drive(input logic v, input logic [7:0] p);
    @(negedge Clk);
    seg_valid = v;
    seg_in    = p;
    @(posedge Clk);
    #1;
    step_no++;
  endtask

  task automatic chk_all(input logic [3:0] esym, input logic esv, input logic efd,
                         input logic eerr, input logic elk, input logic [7:0] ecnt,
                         input logic [2:0] est);
    chk("sym", sym, esym);
    chk("sym_valid", sym_valid, esv);
    chk("frame_done", frame_done, efd);
    chk("err", err, eerr);
    chk("locked", locked, elk);
    chk("frame_cnt", frame_cnt, ecnt);
    chk("state", dbg_state, est);
  endtask

  task automatic send(input logic [7:0] p, input logic [3:0] esym, input logic efd,
                      input logic eerr, input logic elk, input logic [7:0] ecnt,
                      input logic [2:0] est);
    drive(1'b1, p);
    chk_all(esym, 1'b1, efd, eerr, elk, ecnt, est);
  endtask

  // Clean frame; expected frame_done/locked/count on the final 89.
  task automatic clean_frame(input logic lk_before, input logic lk_after, input logic [7:0] cnt_before);
    send(8'hC7, 4'h1, 1'b0, 1'b0, lk_before, cnt_before, 3'd1);
    send(8'hA3, 4'h2, 1'b0, 1'b0, lk_before, cnt_before, 3'd2);
    send(8'hC7, 4'h1, 1'b0, 1'b0, lk_before, cnt_before, 3'd3);
    send(8'hEF, 4'h3, 1'b0, 1'b0, lk_before, cnt_before, 3'd4);
    send(8'h89, 4'h4, 1'b1, 1'b0, lk_after, cnt_before + 8'd1, 3'd0);
  endtask

  logic       blank_lk;
  logic [7:0] blank_cnt;

  initial begin
    Reset_n   = 1'b0;
    seg_in    = 8'h00;
    seg_valid = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk_all(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 3'd0);
    chk("small_cnt_reset", frame_cnt_s, 2'd0);
    @(negedge Clk);
    Reset_n = 1'b1;

    // Three clean frames back to back; lock on the 2nd frame_done.
    clean_frame(1'b0, 1'b0, 8'd0);
    clean_frame(1'b0, 1'b1, 8'd1);
    clean_frame(1'b1, 1'b1, 8'd2);
    chk("small_cnt_3", frame_cnt_s, 2'd3);

    // Corrupt EF with 55 while locked.
    send(8'hC7, 4'h1, 1'b0, 1'b0, 1'b1, 8'd3, 3'd1);
    send(8'hA3, 4'h2, 1'b0, 1'b0, 1'b1, 8'd3, 3'd2);
    send(8'hC7, 4'h1, 1'b0, 1'b0, 1'b1, 8'd3, 3'd3);
    send(8'h55, 4'hF, 1'b0, 1'b1, 1'b0, 8'd3, 3'd0);
    send(8'h89, 4'h4, 1'b0, 1'b0, 1'b0, 8'd3, 3'd0);
    clean_frame(1'b0, 1'b0, 8'd3);
    clean_frame(1'b0, 1'b1, 8'd4);
    chk("small_cnt_sat", frame_cnt_s, 2'd3);

    // seg_valid low for 3 cycles mid-frame: everything holds.
    send(8'hC7, 4'h1, 1'b0, 1'b0, 1'b1, 8'd5, 3'd1);
    send(8'hA3, 4'h2, 1'b0, 1'b0, 1'b1, 8'd5, 3'd2);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'h55);
      chk_all(4'h2, 1'b0, 1'b0, 1'b0, 1'b1, 8'd5, 3'd2);
    end
    send(8'hC7, 4'h1, 1'b0, 1'b0, 1'b1, 8'd5, 3'd3);
    send(8'hEF, 4'h3, 1'b0, 1'b0, 1'b1, 8'd5, 3'd4);
    send(8'h89, 4'h4, 1'b1, 1'b0, 1'b1, 8'd6, 3'd0);

    // Junk while hunting and locked is a mismatch.
    send(8'h55, 4'hF, 1'b0, 1'b1, 1'b0, 8'd6, 3'd0);

    // Prefix overlap: C7,A3,C7,A3 -> IDX2, then C7,EF,89 completes one frame.
    send(8'hC7, 4'h1, 1'b0, 1'b0, 1'b0, 8'd6, 3'd1);
    send(8'hA3, 4'h2, 1'b0, 1'b0, 1'b0, 8'd6, 3'd2);
    send(8'hC7, 4'h1, 1'b0, 1'b0, 1'b0, 8'd6, 3'd3);
    send(8'hA3, 4'h2, 1'b0, 1'b0, 1'b0, 8'd6, 3'd2);
    send(8'hC7, 4'h1, 1'b0, 1'b0, 1'b0, 8'd6, 3'd3);
    send(8'hEF, 4'h3, 1'b0, 1'b0, 1'b0, 8'd6, 3'd4);
    send(8'h89, 4'h4, 1'b1, 1'b0, 1'b0, 8'd7, 3'd0);

    // Blank insertion: C7,FF,A3,C7,EF,89 (good=1 going in).
`ifdef SEG_PATTERN_BLANK_SKIP_EN
    send(8'hC7, 4'h1, 1'b0, 1'b0, 1'b0, 8'd7, 3'd1);
    send(8'hFF, 4'h0, 1'b0, 1'b0, 1'b0, 8'd7, 3'd1);
    send(8'hA3, 4'h2, 1'b0, 1'b0, 1'b0, 8'd7, 3'd2);
    send(8'hC7, 4'h1, 1'b0, 1'b0, 1'b0, 8'd7, 3'd3);
    send(8'hEF, 4'h3, 1'b0, 1'b0, 1'b0, 8'd7, 3'd4);
    send(8'h89, 4'h4, 1'b1, 1'b0, 1'b1, 8'd8, 3'd0);
    blank_lk  = 1'b1;
    blank_cnt = 8'd8;
`else
    send(8'hC7, 4'h1, 1'b0, 1'b0, 1'b0, 8'd7, 3'd1);
    send(8'hFF, 4'h0, 1'b0, 1'b0, 1'b0, 8'd7, 3'd0);
    send(8'hA3, 4'h2, 1'b0, 1'b0, 1'b0, 8'd7, 3'd0);
    send(8'hC7, 4'h1, 1'b0, 1'b0, 1'b0, 8'd7, 3'd1);
    send(8'hEF, 4'h3, 1'b0, 1'b0, 1'b0, 8'd7, 3'd0);
    send(8'h89, 4'h4, 1'b0, 1'b0, 1'b0, 8'd7, 3'd0);
    blank_lk  = 1'b0;
    blank_cnt = 8'd7;
`endif
    chk("blank_locked", locked, blank_lk);
    chk("blank_cnt", frame_cnt, blank_cnt);

    // Asynchronous reset mid-frame, between clock edges.
    send(8'hC7, 4'h1, 1'b0, 1'b0, blank_lk, blank_cnt, 3'd1);
    send(8'hA3, 4'h2, 1'b0, 1'b0, blank_lk, blank_cnt, 3'd2);
    #2;
    Reset_n = 1'b0;
    #1;
    chk_all(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 3'd0);
    chk("small_cnt_async_rst", frame_cnt_s, 2'd0);
    @(negedge Clk);
    Reset_n = 1'b1;

    // Restart from IDX1 on the next C7, then 5 clean frames saturate the 2-bit counter.
    clean_frame(1'b0, 1'b0, 8'd0);
    clean_frame(1'b0, 1'b1, 8'd1);
    clean_frame(1'b1, 1'b1, 8'd2);
    clean_frame(1'b1, 1'b1, 8'd3);
    clean_frame(1'b1, 1'b1, 8'd4);
    chk("small_cnt_final", frame_cnt_s, 2'd3);
    chk("small_locked", locked_s, 1'b1);
    chk("small_err", err_s, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
